usb_rx_packet_checker: RTL and testbench
========================================

# usb_rx_packet_checker

Simulation-side consumer of the deserialized USB byte stream produced by the loopback serializer/deserializer pair. Drains bytes through the rx byte handshake, validates the PID check nibble, runs the CRC5/CRC16 residual check by packet class and buffers the data payload. Publishes one status record per packet, and exposes the payload through a read port for the bench.

## Interface
- `BUF_DEPTH`, default 64: payload bytes stored per packet (power of two, ≥ 2).
- `CLK` input 1: 48 MHz clock, same clock as the rx byte interface.
- `rxRST_N` input 1: reset, asynchronous and active-low.
- `hold` input 1: bench backpressure; while 1, `rxAcceptNewData` is forced 0.
- `rxAcceptNewData` output 1: ready to take a byte.
- `rxIsLastByte` input 1: qualifies the current byte as the last byte of the packet.
- `rxDataValid` input 1: `rxData` is valid.
- `rxData` input 8: received byte, LSB first on the wire.
- `keepPacket` input 1: deserializer verdict, sampled with the last byte.
- `pktDone` output 1: one-cycle pulse; the status record is valid.
- `pktPid` output 4: low nibble of the first byte.
- `pktPidOk` output 1: high nibble == ~low nibble.
- `pktCrcOk` output 1: CRC residual matched; 1 for classes without a CRC.
- `pktLen` output 16: bytes in the packet, including the PID byte.
- `pktOverflow` output 1: payload exceeded `BUF_DEPTH`.
- `pktKeep` output 1: latched `keepPacket`.
- `rdAddr` input $clog2(BUF_DEPTH): payload read address.
- `rdData` output 8: payload byte at `rdAddr`, registered.

## Operation
- States: IDLE, BODY, REPORT.
- Byte transfer occurs on a cycle where `rxDataValid && rxAcceptNewData`. Bytes presented without accept are held by the producer and never dropped.
- `rxAcceptNewData` = !`hold` && state != REPORT.
- **IDLE**, on transfer:
  - Latch the PID byte; `len` = 1; clear both CRC registers and `wrPtr`.
  - If `rxIsLastByte`, go to REPORT; otherwise go to BODY.
- **Class** is taken from PID[1:0]:
  - 01 = token: CRC5 over all following bytes.
  - 11 = data: CRC16 over all following bytes; bytes are stored.
  - 10 = handshake and 00 = special: no CRC, `pktCrcOk` = 1.
- **BODY**, each transfer:
  - `len`++, saturating at 0xFFFF.
  - Feed the byte LSB-first into the class CRC.
  - Data class only: if `wrPtr` < `BUF_DEPTH`, write `buf[wrPtr]` and increment `wrPtr`; otherwise set the overflow flag. The two CRC bytes are stored too; the bench ignores them.
  - On `rxIsLastByte`, go to REPORT.
- **CRC5**: reflected poly 0x14, init 0x1F, good residual 0x06.
- **CRC16**: reflected poly 0xA001, init 0xFFFF, good residual 0xB001.
- **CRC failures**: a token with `len` ≠ 3, or data with `len` < 3, forces `pktCrcOk` = 0.
- **REPORT**: status registers are updated, `pktDone` = 1 for exactly one cycle, then the state returns to IDLE.
- **Status hold**: status outputs hold their values until the next REPORT.
- **Buffer read**: `rdData` <= `buf[rdAddr]` every cycle, independent of state. Content is undefined beyond the last written `wrPtr`.

## Timing
- Reset values:
  - `rxAcceptNewData` = 1 once reset is released (0 while `rxRST_N` = 0).
  - `pktDone`, `pktPidOk`, `pktCrcOk`, `pktOverflow`, `pktKeep` = 0.
  - `pktPid` = 0, `pktLen` = 0, `rdData` = 0.
  - State = IDLE.
- Latency: the last-byte transfer at cycle N gives `pktDone` at N+1. The next packet's first byte is accepted at N+2 at the earliest.
- Single-byte packet: IDLE goes straight to REPORT.
- `hold` toggling mid-packet: no byte is lost or duplicated, and the CRC result is unchanged.
- Reset mid-packet: state returns to IDLE and the partial packet is discarded with no `pktDone`. Buffer content is not cleared.
- `rxDataValid` without `rxIsLastByte` in REPORT: stalled by accept = 0.

## Structure
- Shared package: PID class enum (TOKEN/DATA/HANDSHAKE/SPECIAL), CRC5/CRC16 poly, init and residual constants, and a byte-wise LSB-first CRC update function.
- One sub-module, `usb_crc_checker`: serial-over-byte CRC5 and CRC16 with clear/enable inputs and a residual-match output.
- The payload buffer is inferred inline.

## Test plan
- SETUP token 0x2D 0x00 0x10, no hold -> `pktDone` once; `pktPid`=0xD, `pktPidOk`=1, `pktCrcOk`=1, `pktLen`=3.
- Zero-length DATA1 0x4B 0x00 0x00 with `hold` high for 3 cycles between bytes -> `pktCrcOk`=1, `pktLen`=3, `pktOverflow`=0.
- DATA0 0xC3 0x00 0x01 (corrupt CRC) -> `pktCrcOk`=0, `pktPidOk`=1.
- ACK 0xD2 as a single byte, then bad PID 0xC4 -> first record `pktLen`=1, `pktCrcOk`=1; second record `pktPidOk`=0.
- `BUF_DEPTH`=8, DATA0 with payload 0x00..0x09 plus CRC -> `pktOverflow`=1, `pktLen`=13; `rdAddr` 0..7 reads back 0x00..0x07 one cycle later.
- `rxRST_N` pulsed low after byte 2 of a token, then a full ACK -> exactly one `pktDone`, with `pktPid`=0x2 and `pktLen`=1.

Source files
------------

// File: rtl/usb_rx_packet_checker_pkg.sv
// Shared types and CRC helpers for the USB rx packet checker.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package usb_rx_packet_checker_pkg;

    // Packet class taken from PID[1:0].
    typedef enum logic [1:0] {
        PID_SPECIAL   = 2'b00,
        PID_TOKEN     = 2'b01,
        PID_HANDSHAKE = 2'b10,
        PID_DATA      = 2'b11
    } pid_class_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BODY   = 2'd1,
        ST_REPORT = 2'd2
    } chk_state_t;

    // Reflected (LSB-first) polynomials, seeds and good residuals.
    localparam logic [4:0]  CRC5_POLY  = 5'h14;
    localparam logic [4:0]  CRC5_INIT  = 5'h1F;
    localparam logic [4:0]  CRC5_RES   = 5'h06;
    localparam logic [15:0] CRC16_POLY = 16'hA001;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;
    localparam logic [15:0] CRC16_RES  = 16'hB001;

    // Advance a 5-bit reflected CRC by one byte, bit 0 first.
    function automatic logic [4:0] crc5_update(input logic [4:0] crc, input logic [7:0] data);
        logic [4:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ CRC5_POLY;
            else                c = c >> 1;
        end
        return c;
    endfunction

    // Advance a 16-bit reflected CRC by one byte, bit 0 first.
    function automatic logic [15:0] crc16_update(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ CRC16_POLY;
            else                c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_crc_checker.sv
// Byte-wise CRC5/CRC16 accumulators with residual-match flags.
// Latency: match flags are look-ahead (reflect this cycle's byte when enabled).
// Backpressure: none; caller gates en5/en16 with its own transfer qualifier.
module usb_crc_checker
    import usb_rx_packet_checker_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       en5,
    input  logic       en16,
    input  logic [7:0] data,
    output logic       crc5_match,
    output logic       crc16_match
);

    logic [4:0]  crc5;
    logic [15:0] crc16;
    logic [4:0]  crc5_nxt;
    logic [15:0] crc16_nxt;

    assign crc5_nxt  = crc5_update(crc5, data);
    assign crc16_nxt = crc16_update(crc16, data);

    // Look-ahead so the caller can register a verdict on the last-byte edge.
    assign crc5_match  = ((en5  ? crc5_nxt  : crc5)  == CRC5_RES);
    assign crc16_match = ((en16 ? crc16_nxt : crc16) == CRC16_RES);

    // Accumulators: reseeded on clear, advanced one byte per enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc5  <= CRC5_INIT;
            crc16 <= CRC16_INIT;
        end else if (clear) begin
            crc5  <= CRC5_INIT;
            crc16 <= CRC16_INIT;
        end else begin
            if (en5)  crc5  <= crc5_nxt;
            if (en16) crc16 <= crc16_nxt;
        end
    end

endmodule

// File: rtl/usb_rx_packet_checker.sv
// Drains rx bytes, checks PID nibbles and CRC by class, buffers DATA payload.
// Latency: status record and pktDone one cycle after the last-byte transfer.
// Backpressure: accept drops while hold is high and during the REPORT cycle.
module usb_rx_packet_checker
    import usb_rx_packet_checker_pkg::*;
#(
    parameter int BUF_DEPTH = 64
) (
    input  logic                         CLK,
    input  logic                         rxRST_N,
    input  logic                         hold,
    output logic                         rxAcceptNewData,
    input  logic                         rxIsLastByte,
    input  logic                         rxDataValid,
    input  logic [7:0]                   rxData,
    input  logic                         keepPacket,
    output logic                         pktDone,
    output logic [3:0]                   pktPid,
    output logic                         pktPidOk,
    output logic                         pktCrcOk,
    output logic [15:0]                  pktLen,
    output logic                         pktOverflow,
    output logic                         pktKeep,
    input  logic [$clog2(BUF_DEPTH)-1:0] rdAddr,
    output logic [7:0]                   rdData
);

    localparam int AW = $clog2(BUF_DEPTH);

    chk_state_t  state, state_nxt;
    logic [7:0]  pid_q;
    logic [15:0] len;
    logic [AW:0] wr_ptr;
    logic        ovf;
    logic [7:0]  mem [BUF_DEPTH];

    logic        xfer, first, body, last;
    pid_class_t  cls, rpt_cls;
    logic [7:0]  rpt_pid;
    logic        room, buf_wr;
    logic [15:0] len_nxt;
    logic        ovf_nxt;
    logic        crc5_match, crc16_match;
    logic        crc_ok_nxt;

    assign rxAcceptNewData = rxRST_N && !hold && (state != ST_REPORT);
    assign pktDone         = (state == ST_REPORT);

    assign xfer  = rxDataValid && rxAcceptNewData;
    assign first = xfer && (state == ST_IDLE);
    assign body  = xfer && (state == ST_BODY);
    assign last  = xfer && rxIsLastByte;

    assign cls     = pid_class_t'(pid_q[1:0]);
    assign rpt_pid = first ? rxData : pid_q;
    assign rpt_cls = pid_class_t'(rpt_pid[1:0]);

    assign room    = (wr_ptr < (AW + 1)'(BUF_DEPTH));
    assign buf_wr  = body && (cls == PID_DATA) && room;
    assign len_nxt = first ? 16'd1 : ((len == 16'hFFFF) ? len : len + 16'd1);
    assign ovf_nxt = first ? 1'b0 : (ovf | (body && (cls == PID_DATA) && !room));

    usb_crc_checker u_crc (
        .clk         (CLK),
        .rst_n       (rxRST_N),
        .clear       (first),
        .en5         (body && (cls == PID_TOKEN)),
        .en16        (body && (cls == PID_DATA)),
        .data        (rxData),
        .crc5_match  (crc5_match),
        .crc16_match (crc16_match)
    );

    // Verdict for the packet closing this cycle; length rules override the residual.
    always_comb begin
        crc_ok_nxt = 1'b1;
        case (rpt_cls)
            PID_TOKEN: crc_ok_nxt = (len_nxt == 16'd3) && crc5_match;
            PID_DATA:  crc_ok_nxt = (len_nxt >= 16'd3) && crc16_match;
            default:   crc_ok_nxt = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge rxRST_N) begin
        if (!rxRST_N) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next state: a single-byte packet goes straight from IDLE to REPORT.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (xfer) state_nxt = rxIsLastByte ? ST_REPORT : ST_BODY;
            ST_BODY:   if (last) state_nxt = ST_REPORT;
            ST_REPORT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Per-packet working registers: seeded by the PID byte, advanced by body bytes.
    always_ff @(posedge CLK or negedge rxRST_N) begin
        if (!rxRST_N) begin
            pid_q  <= '0;
            len    <= '0;
            wr_ptr <= '0;
            ovf    <= 1'b0;
        end else if (first) begin
            pid_q  <= rxData;
            len    <= 16'd1;
            wr_ptr <= '0;
            ovf    <= 1'b0;
        end else if (body) begin
            len <= len_nxt;
            ovf <= ovf_nxt;
            if (buf_wr) wr_ptr <= wr_ptr + 1'b1;
        end
    end

    // Status record captured on the last-byte edge and held until the next packet closes.
    always_ff @(posedge CLK or negedge rxRST_N) begin
        if (!rxRST_N) begin
            pktPid      <= '0;
            pktPidOk    <= 1'b0;
            pktCrcOk    <= 1'b0;
            pktLen      <= '0;
            pktOverflow <= 1'b0;
            pktKeep     <= 1'b0;
        end else if (last) begin
            pktPid      <= rpt_pid[3:0];
            pktPidOk    <= (rpt_pid[7:4] == ~rpt_pid[3:0]);
            pktCrcOk    <= crc_ok_nxt;
            pktLen      <= len_nxt;
            pktOverflow <= ovf_nxt;
            pktKeep     <= keepPacket;
        end
    end

    // Payload storage; deliberately not cleared by reset.
    always_ff @(posedge CLK) begin
        if (buf_wr) mem[wr_ptr[AW-1:0]] <= rxData;
    end

    // Registered read port, free-running.
    always_ff @(posedge CLK or negedge rxRST_N) begin
        if (!rxRST_N) rdData <= '0;
        else          rdData <= mem[rdAddr];
    end

endmodule

// File: tb/tb_usb_rx_packet_checker.sv
// Self-checking bench for usb_rx_packet_checker (BUF_DEPTH = 8).
// Packets come from a vector table; expected status records queue in a scoreboard.
// A negedge monitor pops one record per pktDone and compares every field.
module tb_usb_rx_packet_checker;

    localparam int DEPTH = 8;

    logic        CLK = 1'b0;
    logic        rxRST_N;
    logic        hold;
    logic        rxAcceptNewData;
    logic        rxIsLastByte;
    logic        rxDataValid;
    logic [7:0]  rxData;
    logic        keepPacket;
    logic        pktDone;
    logic [3:0]  pktPid;
    logic        pktPidOk;
    logic        pktCrcOk;
    logic [15:0] pktLen;
    logic        pktOverflow;
    logic        pktKeep;
    logic [2:0]  rdAddr;
    logic [7:0]  rdData;

    usb_rx_packet_checker #(.BUF_DEPTH(DEPTH)) dut (
        .CLK             (CLK),
        .rxRST_N         (rxRST_N),
        .hold            (hold),
        .rxAcceptNewData (rxAcceptNewData),
        .rxIsLastByte    (rxIsLastByte),
        .rxDataValid     (rxDataValid),
        .rxData          (rxData),
        .keepPacket      (keepPacket),
        .pktDone         (pktDone),
        .pktPid          (pktPid),
        .pktPidOk        (pktPidOk),
        .pktCrcOk        (pktCrcOk),
        .pktLen          (pktLen),
        .pktOverflow     (pktOverflow),
        .pktKeep         (pktKeep),
        .rdAddr          (rdAddr),
        .rdData          (rdData)
    );

    always #10 CLK = ~CLK;

    typedef struct packed {
        logic [3:0]  pid;
        logic        pid_ok;
        logic        crc_ok;
        logic [15:0] len;
        logic        ovf;
        logic        keep;
    } exp_t;

    typedef struct packed {
        logic [15:0][7:0] bytes;
        logic [4:0]       n;
        logic [3:0]       gap_at;
        logic [2:0]       gap;
        logic             keep;
        exp_t             exp;
    } pkt_vec_t;

    localparam int NVEC = 9;
    pkt_vec_t vecs [NVEC];
    exp_t     sb [$];

    int  n_checks = 0;
    int  n_fail   = 0;
    time t_last   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Independent reference CRC16 (USB, reflected) for building good DATA packets.
    function automatic logic [15:0] ref_crc16(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ b[i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    function automatic exp_t mk_exp(input logic [3:0] pid, input logic pid_ok, input logic crc_ok,
                                    input logic [15:0] len, input logic ovf, input logic keep);
        exp_t e;
        e.pid = pid; e.pid_ok = pid_ok; e.crc_ok = crc_ok;
        e.len = len; e.ovf = ovf; e.keep = keep;
        return e;
    endfunction

    // Presents one byte and waits (bounded) until it is accepted.
    task automatic send_byte(input logic [7:0] d, input logic lst, input logic kp, input int gap);
        int   t;
        logic done;
        rxData       = d;
        rxDataValid  = 1'b1;
        rxIsLastByte = lst;
        keepPacket   = lst ? kp : 1'b0;
        if (gap > 0) begin
            hold = 1'b1;
            repeat (gap) begin
                @(negedge CLK);
                check("accept_low_on_hold", 16'(rxAcceptNewData), 16'd0);
                @(posedge CLK); #1;
            end
            hold = 1'b0;
        end
        done = 1'b0;
        t    = 0;
        while (!done) begin
            @(negedge CLK);
            done = rxAcceptNewData;
            if (done && lst) t_last = $time;
            @(posedge CLK); #1;
            t++;
            if (!done && t >= 64) begin
                fail_now("byte_accept_timeout");
                done = 1'b1;
            end
        end
        rxDataValid  = 1'b0;
        rxIsLastByte = 1'b0;
        keepPacket   = 1'b0;
    endtask

    task automatic send_pkt(input pkt_vec_t v);
        sb.push_back(v.exp);
        for (int i = 0; i < int'(v.n); i++) begin
            send_byte(v.bytes[i], (i == int'(v.n) - 1), v.keep,
                      (i == int'(v.gap_at)) ? int'(v.gap) : 0);
        end
    endtask

    // Scoreboard monitor: one record per pktDone, checked one cycle after the last byte.
    always @(negedge CLK) begin
        exp_t e;
        if (rxRST_N === 1'b1 && pktDone === 1'b1) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_pktDone");
            end else begin
                e = sb.pop_front();
                check("pktPid",      16'(pktPid),      16'(e.pid));
                check("pktPidOk",    16'(pktPidOk),    16'(e.pid_ok));
                check("pktCrcOk",    16'(pktCrcOk),    16'(e.crc_ok));
                check("pktLen",      pktLen,           e.len);
                check("pktOverflow", 16'(pktOverflow), 16'(e.ovf));
                check("pktKeep",     16'(pktKeep),     16'(e.keep));
                check("done_latency", 16'($time - t_last), 16'd20);
            end
        end
    end

    initial begin
        logic [15:0] c;
        pkt_vec_t    v;
        int          t;

        // Vector table.
        v = '0; v.n = 3; v.keep = 1'b1;
        v.bytes[0] = 8'h2D; v.bytes[1] = 8'h00; v.bytes[2] = 8'h10;
        v.exp = mk_exp(4'hD, 1'b1, 1'b1, 16'd3, 1'b0, 1'b1);
        vecs[0] = v;

        v = '0; v.n = 3; v.gap_at = 4'd1; v.gap = 3'd3;
        v.bytes[0] = 8'h4B; v.bytes[1] = 8'h00; v.bytes[2] = 8'h00;
        v.exp = mk_exp(4'hB, 1'b1, 1'b1, 16'd3, 1'b0, 1'b0);
        vecs[1] = v;

        v = '0; v.n = 3; v.keep = 1'b1;
        v.bytes[0] = 8'hC3; v.bytes[1] = 8'h00; v.bytes[2] = 8'h01;
        v.exp = mk_exp(4'h3, 1'b1, 1'b0, 16'd3, 1'b0, 1'b1);
        vecs[2] = v;

        v = '0; v.n = 1; v.gap_at = 4'hF;
        v.bytes[0] = 8'hD2;
        v.exp = mk_exp(4'h2, 1'b1, 1'b1, 16'd1, 1'b0, 1'b0);
        vecs[3] = v;

        v = '0; v.n = 1; v.gap_at = 4'hF; v.keep = 1'b1;
        v.bytes[0] = 8'hC4;
        v.exp = mk_exp(4'h4, 1'b0, 1'b1, 16'd1, 1'b0, 1'b1);
        vecs[4] = v;

        v = '0; v.n = 3; v.gap_at = 4'hF;
        v.bytes[0] = 8'h2D; v.bytes[1] = 8'h00; v.bytes[2] = 8'h11;
        v.exp = mk_exp(4'hD, 1'b1, 1'b0, 16'd3, 1'b0, 1'b0);
        vecs[5] = v;

        v = '0; v.n = 2; v.gap_at = 4'hF;
        v.bytes[0] = 8'hE1; v.bytes[1] = 8'h00;
        v.exp = mk_exp(4'h1, 1'b1, 1'b0, 16'd2, 1'b0, 1'b0);
        vecs[6] = v;

        v = '0; v.n = 5; v.gap_at = 4'd2; v.gap = 3'd2; v.keep = 1'b1;
        v.bytes[0] = 8'hC3; v.bytes[1] = 8'hA5; v.bytes[2] = 8'h5A;
        c = 16'hFFFF; c = ref_crc16(c, 8'hA5); c = ref_crc16(c, 8'h5A);
        v.bytes[3] = ~c[7:0]; v.bytes[4] = ~c[15:8];
        v.exp = mk_exp(4'h3, 1'b1, 1'b1, 16'd5, 1'b0, 1'b1);
        vecs[7] = v;

        v = '0; v.n = 13; v.gap_at = 4'd5; v.gap = 3'd1;
        v.bytes[0] = 8'hC3;
        c = 16'hFFFF;
        for (int i = 0; i < 10; i++) begin
            v.bytes[i + 1] = 8'(i);
            c = ref_crc16(c, 8'(i));
        end
        v.bytes[11] = ~c[7:0]; v.bytes[12] = ~c[15:8];
        v.exp = mk_exp(4'h3, 1'b1, 1'b1, 16'd13, 1'b1, 1'b0);
        vecs[8] = v;

        // Reset state.
        rxRST_N = 1'b0; hold = 1'b0; rxIsLastByte = 1'b0; rxDataValid = 1'b0;
        rxData = 8'h00; keepPacket = 1'b0; rdAddr = 3'd0;
        #25;
        check("rst_accept",   16'(rxAcceptNewData), 16'd0);
        check("rst_pktDone",  16'(pktDone),         16'd0);
        check("rst_pktPid",   16'(pktPid),          16'd0);
        check("rst_pktLen",   pktLen,               16'd0);
        check("rst_pidok",    16'(pktPidOk),        16'd0);
        check("rst_crcok",    16'(pktCrcOk),        16'd0);
        check("rst_ovf",      16'(pktOverflow),     16'd0);
        check("rst_keep",     16'(pktKeep),         16'd0);
        check("rst_rdData",   16'(rdData),          16'd0);
        @(negedge CLK); rxRST_N = 1'b1;
        @(posedge CLK); #1;
        check("accept_after_rst", 16'(rxAcceptNewData), 16'd1);

        // Table-driven packets, back to back.
        for (int k = 0; k < NVEC; k++) send_pkt(vecs[k]);

        // Payload read-back of the overflowed packet (first DEPTH bytes kept).
        repeat (2) @(posedge CLK);
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            rdAddr = 3'(i);
            @(posedge CLK);
            @(negedge CLK);
            check("rdData", 16'(rdData), 16'(i));
            #1;
        end

        // Reset in the middle of a token, then a full ACK.
        send_byte(8'h2D, 1'b0, 1'b0, 0);
        send_byte(8'h00, 1'b0, 1'b0, 0);
        @(negedge CLK);
        rxRST_N = 1'b0;
        #3;
        check("midrst_accept",  16'(rxAcceptNewData), 16'd0);
        check("midrst_pktDone", 16'(pktDone),         16'd0);
        @(negedge CLK);
        rxRST_N = 1'b1;
        @(posedge CLK); #1;
        check("midrst_len_cleared", pktLen, 16'd0);
        check("midrst_accept_back", 16'(rxAcceptNewData), 16'd1);
        v = '0; v.n = 1; v.gap_at = 4'hF;
        v.bytes[0] = 8'hD2;
        v.exp = mk_exp(4'h2, 1'b1, 1'b1, 16'd1, 1'b0, 1'b0);
        send_pkt(v);

        // Drain the scoreboard with a bounded wait.
        t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(posedge CLK);
            t++;
        end
        repeat (4) @(posedge CLK);
        check("scoreboard_empty", 16'(sb.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
